// File: rtl/des_pkg.sv
// Shared DES constants and the round-sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package des_pkg;

    localparam int DES_ROUNDS = 16;
    localparam int HALF_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/des_round_sequencer.sv
// Iterative DES Feistel controller: time-shares one external round function over all rounds.
// Latency: start accepted in cycle 0 -> out_valid in cycle NUM_ROUNDS+1; one block per NUM_ROUNDS+2 cycles.
// Backpressure: pre_out/out_valid held in HOLD until out_ready; start is ignored while busy.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start/decrypt     block request and mode (1 = reverse subkey order), sampled only when idle
//   ip_block          post-IP block, bits [63:32] = L0 (DES bit 1 is the MSB), [31:0] = R0
//   busy              high from the cycle after acceptance until the result is taken
//   f_in/subkey_idx   current R half and subkey select for the shared round function
//   f_out             combinational round-function result for f_in/subkey_idx
//   pre_out           swapped preoutput {R_n, L_n} for the final permutation
//   out_valid/ready   result handshake
module des_round_sequencer
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [2*HALF_W-1:0]   ip_block,
    output logic                  busy,
    output logic [HALF_W-1:0]     f_in,
    output logic [3:0]            subkey_idx,
    input  logic [HALF_W-1:0]     f_out,
    output logic [2*HALF_W-1:0]   pre_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    state_t               state_q;
    logic [HALF_W-1:0]    l_q;
    logic [HALF_W-1:0]    r_q;
    logic [HALF_W-1:0]    r_d;
    logic [3:0]           cnt_q;
    logic                 mode_q;
    logic                 busy_q;
    logic                 out_valid_q;
    logic [2*HALF_W-1:0]  pre_out_q;

    // Feistel update of the right half for the current round.
    assign r_d = l_q ^ f_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            pre_out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        l_q     <= ip_block[2*HALF_W-1:HALF_W];
                        r_q     <= ip_block[HALF_W-1:0];
                        mode_q  <= decrypt;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    l_q <= r_q;
                    r_q <= r_d;
                    if (cnt_q == LAST_CNT) begin
                        // Capture the swapped halves {R_n, L_n} straight from this
                        // round's update so pre_out is valid on entry to HOLD.
                        // The counter is frozen so subkey_idx never wraps.
                        pre_out_q   <= {r_d, r_q};
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decrypt walks the key schedule backwards; both operands are registers,
    // so the select is stable for the whole round cycle.
    assign subkey_idx = mode_q ? (LAST_CNT - cnt_q) : cnt_q;
    assign f_in       = r_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign pre_out    = pre_out_q;

endmodule
